mealy_seq_detector: RTL and testbench
=====================================

// Module: mealy_seq_detector
// PURPOSE
//   Parametrised Mealy sequence detector for a serial bit stream.
//   Detects a compile-time PATTERN of PAT_LEN bits, with overlapping or
//   non-overlapping match mode and a saturating match counter.
//   Successor to the fixed 4-state Mealy FSM. Sits directly on a serial
//   input stream, with an in_valid qualifier from the upstream sampler.
// PARAMETERS
//   PAT_LEN  4        pattern length in bits, 2..16
//   PATTERN  4'b1011  pattern; PATTERN[PAT_LEN-1] is the first bit received
//   OVERLAP  1        1: matches may overlap; 0: restart from S0 after a match
//   CNT_W    8        width of the match counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          x is sampled on this cycle
//   x          in   1          serial data bit
//   clear      in   1          synchronous clear of state and counter
//   y          out  1          match pulse (Mealy; see BEHAVIOUR)
//   state_o    out  SW         current state, SW = $clog2(PAT_LEN)
//   match_cnt  out  CNT_W      saturating count of matches
// BEHAVIOUR
//   - States: S0..S(PAT_LEN-1). Sk means k leading pattern bits are matched.
//   - Transitions are applied on posedge clk only when in_valid=1.
//     Otherwise the state holds and y=0.
//   - In Sk with x == expected bit, k < PAT_LEN-1: next state is S(k+1), y=0.
//   - In Sk with x != expected bit: next state is Sj, where j is the longest
//     proper prefix of PATTERN that is a suffix of (matched bits, x).
//     This is the KMP fallback; the table is computed at elaboration.
//   - In S(PAT_LEN-1) with x == last bit: y=1, meaning a match.
//     OVERLAP=1: next state = S(f), f = KMP failure value of the full pattern.
//     OVERLAP=0: next state = S0.
//   - y is combinational from (state, x, in_valid, clear). Zero latency:
//     y asserts in the same cycle as the final pattern bit.
//   - match_cnt increments on each cycle with y=1 and saturates at
//     2^CNT_W-1. It does not wrap.
//   - clear=1: next state is S0, match_cnt goes to 0, y is forced to 0.
//     clear beats a simultaneous match.
//   - rst=1: state S0, match_cnt 0, y 0. rst has priority over clear.
//     Any partial match in progress is discarded.
//   - state_o reflects the registered state. It resets to 0.
//   - Illegal parameters (PAT_LEN < 2 or PAT_LEN > 16) cause an
//     elaboration error via $error in a generate block.
// CONFIGURATION
//   MEALY_SEQ_DET_REG_OUT_EN defined:
//     y is registered. It pulses one cycle after the final bit.
//     Registered y resets to 0 and clears on clear.
//     match_cnt still updates on the match cycle.
//   MEALY_SEQ_DET_REG_OUT_EN undefined:
//     y is purely combinational with zero latency, as described above.
// STRUCTURE
//   - Package mealy_seq_det_pkg holds:
//     state-width function clog2_min1(), the function kmp_next(PATTERN,
//     PAT_LEN, k, x) returning the next state, and constant
//     MAX_PAT_LEN = 16.
//   - Sub-module mealy_seq_det_sat_cnt #(CNT_W) implements the saturating
//     counter with inc, clr and rst inputs.
//   - Top level holds the state register, the elaborated next-state
//     table and the output logic.
// TESTING
//   1. Defaults, OVERLAP=1, in_valid=1, x = 1,0,1,1,0,1,1
//      -> y=1 on bits 4 and 7; match_cnt=2.
//   2. OVERLAP=0, same stream -> y=1 on bit 4 only; match_cnt=1;
//      state_o=1 after bit 7.
//   3. Stream 1,0,1,0,1,1 (fallback S3 -> S2 on the 4th bit)
//      -> y=1 on bit 6 only.
//   4. in_valid=0 on bits 2-3 of 1,0,1,1 with junk x on those cycles
//      -> state holds, y stays 0 on the gaps, match still fires on the last
//      valid bit.
//   5. CNT_W=2, 5 consecutive overlapping matches -> match_cnt sticks at 3.
//   6. clear asserted together with the final pattern bit -> y=0, state_o=0,
//      match_cnt=0. Repeat with rst mid-pattern -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mealy_seq_det_pkg.sv
// Shared constants and elaboration-time helpers for mealy_seq_detector:
// state-width calculation and the KMP next-state function.
package mealy_seq_det_pkg;

   localparam int MAX_PAT_LEN = 16;

   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Bit idx of the pattern in reception order (idx 0 is received first).
   function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern,
                                    input int pat_len, input int idx);
      return 1'(pattern >> (pat_len - 1 - idx));
   endfunction

   function automatic logic vec_bit(input logic [MAX_PAT_LEN-1:0] v, input int idx);
      return 1'(v >> idx);
   endfunction

   // From state k (k bits matched) on input x: the longest proper prefix of
   // the pattern that is a suffix of (matched bits, x). A full match
   // therefore lands on the failure value of the whole pattern.
   function automatic int kmp_next(input logic [MAX_PAT_LEN-1:0] pattern,
                                   input int pat_len, input int k, input logic x);
      logic [MAX_PAT_LEN-1:0] s;
      logic                   b;
      logic                   ok;
      int                     best;
      s    = '0;
      best = 0;
      for (int i = 0; i < MAX_PAT_LEN; i++) begin
         b = (i < k) ? pat_bit(pattern, pat_len, i) : x;
         if (i <= k && b) s = s | (MAX_PAT_LEN'(1) << i);
      end
      for (int j = 1; j < MAX_PAT_LEN; j++) begin
         if (j <= k + 1 && j < pat_len) begin
            ok = 1'b1;
            for (int t = 0; t < MAX_PAT_LEN; t++) begin
               if (t < j && pat_bit(pattern, pat_len, t) != vec_bit(s, k + 1 - j + t))
                  ok = 1'b0;
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/mealy_seq_det_sat_cnt.sv
// Saturating up-counter for the match count; holds at all-ones instead of
// wrapping. rst has priority over clr.
module mealy_seq_det_sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy detector for PATTERN on a qualified serial stream.
// Define MEALY_SEQ_DET_REG_OUT_EN to register y (one cycle after the final bit).
module mealy_seq_detector
   import mealy_seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8,
   localparam int                SW      = clog2_min1(PAT_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             x,
   input  logic             clear,
   output logic             y,
   output logic [SW-1:0]    state_o,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int                     NS      = 1 << SW;
   localparam logic [MAX_PAT_LEN-1:0] PAT_EXT = MAX_PAT_LEN'(PATTERN);
   localparam logic [SW-1:0]          LAST_ST = SW'(PAT_LEN - 1);

   generate
      if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
         $error("mealy_seq_detector: PAT_LEN must be in 2..16");
      end
   endgenerate

   // Next-state table indexed by state, one column per input bit value.
   logic [SW-1:0] nxt0 [NS];
   logic [SW-1:0] nxt1 [NS];

   generate
      for (genvar k = 0; k < NS; k++) begin : g_tbl
         if (k < PAT_LEN) begin : g_live
            assign nxt0[k] = SW'(kmp_next(PAT_EXT, PAT_LEN, k, 1'b0));
            assign nxt1[k] = SW'(kmp_next(PAT_EXT, PAT_LEN, k, 1'b1));
         end else begin : g_unused
            assign nxt0[k] = '0;
            assign nxt1[k] = '0;
         end
      end
   endgenerate

   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;
   logic          match;
   logic          hit;

   always_comb begin
      match   = in_valid && (state_q == LAST_ST) && (x == PATTERN[0]);
      hit     = match && !clear && !rst;
      state_d = x ? nxt1[state_q] : nxt0[state_q];
      if (match && !OVERLAP) state_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst)           state_q <= '0;
      else if (clear)    state_q <= '0;
      else if (in_valid) state_q <= state_d;
   end

   assign state_o = state_q;

`ifdef MEALY_SEQ_DET_REG_OUT_EN
   logic y_q;

   always_ff @(posedge clk) begin
      if (rst) y_q <= 1'b0;
      else     y_q <= hit;
   end

   assign y = y_q;
`else
   assign y = hit;
`endif

   mealy_seq_det_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_i (rst),
      .clr_i (clear),
      .inc_i (hit),
      .cnt_o (match_cnt)
   );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus and are compared against a history-based model.
module tb_mealy_seq_detector;

   logic clk = 1'b0;
   logic rst, in_valid, x, clear;

   logic       y0, y1, y2;
   logic [1:0] st0, st1, st2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   always #5 clk = ~clk;

   mealy_seq_detector dut_ov (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
      .y(y0), .state_o(st0), .match_cnt(cnt0));

   mealy_seq_detector #(.OVERLAP(1'b0)) dut_no (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
      .y(y1), .state_o(st1), .match_cnt(cnt1));

   mealy_seq_detector #(.CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
      .y(y2), .state_o(st2), .match_cnt(cnt2));

   int n_vec = 0;
   int n_err = 0;

   // Model: received bits since last reset/clear (or non-overlapping match).
   bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   bit hist [3][$];
   int cnt_m [3];
   bit yprev [3];
   bit ovl [3]    = '{1'b1, 1'b0, 1'b1};
   int cntmax [3] = '{255, 255, 3};

   function automatic bit full_match(int m, bit xb);
      int sz;
      sz = hist[m].size();
      if (sz < 3) return 1'b0;
      return (hist[m][sz-3] == pat[0]) && (hist[m][sz-2] == pat[1]) &&
             (hist[m][sz-1] == pat[2]) && (xb == pat[3]);
   endfunction

   function automatic int exp_state(int m);
      int sz;
      bit ok;
      sz = hist[m].size();
      for (int len = 3; len > 0; len--) begin
         if (len <= sz) begin
            ok = 1'b1;
            for (int t = 0; t < len; t++)
               if (hist[m][sz-len+t] != pat[t]) ok = 1'b0;
            if (ok) return len;
         end
      end
      return 0;
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
      end
   endtask

   function automatic int obs_y(int m);
      return (m == 0) ? int'(y0) : (m == 1) ? int'(y1) : int'(y2);
   endfunction
   function automatic int obs_st(int m);
      return (m == 0) ? int'(st0) : (m == 1) ? int'(st1) : int'(st2);
   endfunction
   function automatic int obs_cnt(int m);
      return (m == 0) ? int'(cnt0) : (m == 1) ? int'(cnt1) : int'(cnt2);
   endfunction

   task automatic step(input bit r, input bit v, input bit xb, input bit c);
      bit hit [3];
      int ey;
      rst = r; in_valid = v; x = xb; clear = c;
      #2;
      for (int m = 0; m < 3; m++) begin
         hit[m] = !r && !c && v && full_match(m, xb);
`ifdef MEALY_SEQ_DET_REG_OUT_EN
         ey = int'(yprev[m]);
`else
         ey = int'(hit[m]);
`endif
         chk($sformatf("y[%0d]", m), obs_y(m), ey);
         chk($sformatf("state[%0d]", m), obs_st(m), exp_state(m));
         chk($sformatf("cnt[%0d]", m), obs_cnt(m), cnt_m[m]);
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 3; m++) begin
         yprev[m] = hit[m];
         if (r || c) begin
            hist[m].delete();
            cnt_m[m] = 0;
         end else if (v) begin
            hist[m].push_back(xb);
            if (hist[m].size() > 8) void'(hist[m].pop_front());
            if (hit[m]) begin
               if (cnt_m[m] < cntmax[m]) cnt_m[m]++;
               if (!ovl[m]) hist[m].delete();
            end
         end
      end
   endtask

   task automatic run_bits(input bit [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; x = 1'b0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_y", int'(y0), 0);
      chk("rst_state", int'(st0), 0);
      chk("rst_cnt", int'(cnt0), 0);
      chk("rst_cnt_c2", int'(cnt2), 0);
      for (int m = 0; m < 3; m++) begin
         hist[m].delete(); cnt_m[m] = 0; yprev[m] = 1'b0;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Overlap vs non-overlap on 1011011.
      run_bits(16'b1011011, 7);
      chk("t1_cnt_ov", int'(cnt0), 2);
      chk("t1_cnt_no", int'(cnt1), 1);
      chk("t2_state_no", int'(st1), 1);

      // KMP fallback S3 -> S2.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      run_bits(16'b101011, 6);
      chk("t3_cnt", int'(cnt0), 1);

      // Valid gaps with junk data.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      run_bits(16'b011, 3);
      chk("t4_cnt", int'(cnt0), 1);

      // Five overlapping matches saturate the 2-bit counter.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      run_bits(16'b1011011011011011, 16);
      chk("t5_cnt_c2", int'(cnt2), 3);
      chk("t5_cnt_ov", int'(cnt0), 5);

      // Clear with the final bit, then reset mid-pattern.
      run_bits(16'b101, 3);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("t6_clr_state", int'(st0), 0);
      chk("t6_clr_cnt", int'(cnt0), 0);
      run_bits(16'b101, 3);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t6_rst_state", int'(st0), 0);
      chk("t6_rst_cnt", int'(cnt2), 0);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(99) < 2, $urandom_range(99) < 80,
              1'($urandom), $urandom_range(99) < 3);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
